// File: rtl/bc_horner.sv
// Control sequencer for a Horner-rule polynomial datapath.
// A run with degree n walks INIT, then n MUL/ADD pairs, then a one-cycle DONE.
module bc_horner #(
    parameter int GRAU_MAX = 7,
    parameter int IDX_W    = $clog2(GRAU_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [IDX_W-1:0] grau,
    output logic [1:0]       m0,
    output logic [1:0]       m1,
    output logic [1:0]       m2,
    output logic             lx,
    output logic             ls,
    output logic             lh,
    output logic             h,
    output logic [IDX_W-1:0] idx,
    output logic             ocupado,
    output logic             pronto
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MUL,
        S_ADD,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] GMAX = IDX_W'(GRAU_MAX);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx_r, idx_n;
    logic [IDX_W-1:0] deg_r, deg_n;
    logic [IDX_W-1:0] grau_clamped;

    assign grau_clamped = (grau > GMAX) ? GMAX : grau;
    assign idx          = idx_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx_r <= '0;
            deg_r <= '0;
        end else begin
            state <= state_n;
            idx_r <= idx_n;
            deg_r <= deg_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx_r;
        deg_n   = deg_r;
        m0      = 2'b01;
        m1      = 2'b01;
        m2      = 2'b00;
        lx      = 1'b1;
        ls      = 1'b0;
        lh      = 1'b0;
        h       = 1'b1;
        ocupado = 1'b0;
        pronto  = 1'b0;

        case (state)
            S_IDLE: begin
                if (inicio) begin
                    state_n = S_INIT;
                    idx_n   = grau_clamped;
                    deg_n   = grau_clamped;
                end
            end
            S_INIT: begin
                m0      = 2'b00;
                m1      = 2'b00;
                m2      = 2'b11;
                lx      = 1'b0;
                ls      = 1'b1;
                ocupado = 1'b1;
                if (deg_r == '0) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_MUL;
                    if (idx_r != '0) idx_n = idx_r - IDX_W'(1);
                end
            end
            S_MUL: begin
                m0      = 2'b10;
                m1      = 2'b11;
                m2      = 2'b10;
                lx      = 1'b0;
                lh      = 1'b1;
                h       = 1'b0;
                ocupado = 1'b1;
                state_n = S_ADD;
            end
            S_ADD: begin
                m0      = 2'b11;
                m1      = 2'b00;
                m2      = 2'b00;
                lx      = 1'b0;
                ls      = 1'b1;
                ocupado = 1'b1;
                if (idx_r == '0) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_MUL;
                    idx_n   = idx_r - IDX_W'(1);
                end
            end
            S_DONE: begin
                m0      = 2'b00;
                m1      = 2'b00;
                m2      = 2'b00;
                lx      = 1'b0;
                h       = 1'b0;
                ocupado = 1'b1;
                pronto  = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                idx_n   = '0;
                deg_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bc_horner.sv
// Directed bench for bc_horner with a small behavioural datapath driven by its
// control outputs; each cycle's outputs are compared against per-state patterns.
module tb_bc_horner;

    localparam int GM = 7;
    localparam int IW = 4;

    // {m0, m1, m2, lx, ls, lh, h, ocupado, pronto}
    localparam logic [12:0] P_IDLE = 13'b01_01_00_1_0_0_1_0_0;
    localparam logic [12:0] P_INIT = 13'b00_00_11_0_1_0_1_1_0;
    localparam logic [12:0] P_MUL  = 13'b10_11_10_0_0_1_0_1_0;
    localparam logic [12:0] P_ADD  = 13'b11_00_00_0_1_0_1_1_0;
    localparam logic [12:0] P_DONE = 13'b00_00_00_0_0_0_0_1_1;

    logic          clk = 1'b0;
    logic          rst;
    logic          inicio;
    logic [IW-1:0] grau;
    logic [1:0]    m0, m1, m2;
    logic          lx, ls, lh, h, ocupado, pronto;
    logic [IW-1:0] idx;
    logic [12:0]   outs;

    logic [31:0] xin;
    logic [31:0] a [16];
    logic [31:0] xr, sr, hr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bc_horner #(.GRAU_MAX(GM), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .grau(grau),
        .m0(m0), .m1(m1), .m2(m2), .lx(lx), .ls(ls), .lh(lh), .h(h),
        .idx(idx), .ocupado(ocupado), .pronto(pronto)
    );

    assign outs = {m0, m1, m2, lx, ls, lh, h, ocupado, pronto};

    // Datapath: X follows xin when lx; H <= S*X; S <= a[idx] (m2=11) or H + a[idx]
    always @(posedge clk) begin
        if (lx) xr <= xin;
        if (lh) hr <= sr * xr;
        if (ls) sr <= (m2 == 2'b11) ? a[idx] : hr + a[idx];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic [12:0] pat, input int expidx);
        check({tag, " outs"}, 32'(outs), 32'(pat));
        check({tag, " idx"}, 32'(idx), expidx[31:0]);
    endtask

    // Starts a run from IDLE with grau already set; n is the effective degree.
    task automatic run(input string tag, input int n, input logic [31:0] exp_s);
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        chk_cycle({tag, " init"}, P_INIT, n);
        for (int k = 1; k <= n; k++) begin
            step();
            chk_cycle({tag, " mul"}, P_MUL, n - k);
            step();
            chk_cycle({tag, " add"}, P_ADD, n - k);
        end
        step();
        chk_cycle({tag, " done"}, P_DONE, 0);
        check({tag, " y"}, sr, exp_s);
        step();
        chk_cycle({tag, " idle"}, P_IDLE, 0);
    endtask

    initial begin
        rst    = 1'b1;
        inicio = 1'b1;
        grau   = 4'd3;
        xin    = 32'd3;
        for (int i = 0; i < 16; i++) a[i] = 32'd0;

        // Reset dominates a pending start
        step();
        chk_cycle("rst1", P_IDLE, 0);
        step();
        chk_cycle("rst2", P_IDLE, 0);
        rst    = 1'b0;
        inicio = 1'b0;
        step();
        chk_cycle("idle0", P_IDLE, 0);

        // grau=2, x=3, a2=2 a1=1 a0=5 -> 26; stray start and grau change mid-run ignored
        a[2] = 32'd2; a[1] = 32'd1; a[0] = 32'd5;
        grau   = 4'd2;
        inicio = 1'b1;
        step(); inicio = 1'b0;
        chk_cycle("g2 c1", P_INIT, 2);
        step();
        chk_cycle("g2 c2", P_MUL, 1);
        inicio = 1'b1; grau = 4'd5;
        step();
        chk_cycle("g2 c3", P_ADD, 1);
        inicio = 1'b0;
        step();
        chk_cycle("g2 c4", P_MUL, 0);
        step();
        chk_cycle("g2 c5", P_ADD, 0);
        step();
        chk_cycle("g2 c6", P_DONE, 0);
        check("g2 y", sr, 32'd26);
        step();
        chk_cycle("g2 c7", P_IDLE, 0);

        // Degree 0 -> S = a0
        grau = 4'd0;
        run("g0", 0, 32'd5);

        // Clamp: grau=10 behaves as 7; x=2, all ones -> 255
        for (int i = 0; i < 16; i++) a[i] = 32'd1;
        xin  = 32'd2;
        grau = 4'd10;
        step();
        run("clamp", 7, 32'd255);

        // Reset during the second MUL of a grau=3 run
        grau   = 4'd3;
        inicio = 1'b1;
        step(); inicio = 1'b0;
        chk_cycle("ab c1", P_INIT, 3);
        step();
        step();
        step();
        chk_cycle("ab c4", P_MUL, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cycle("ab rst", P_IDLE, 0);
        step();
        chk_cycle("ab idle", P_IDLE, 0);
        run("ab rerun", 3, 32'd15);

        // Start held high with grau=1: period of 5 cycles, x=2, a1=a0=1 -> 3
        grau   = 4'd1;
        inicio = 1'b1;
        for (int p = 0; p < 2; p++) begin
            step();
            chk_cycle("hold init", P_INIT, 1);
            step();
            chk_cycle("hold mul", P_MUL, 0);
            step();
            chk_cycle("hold add", P_ADD, 0);
            step();
            chk_cycle("hold done", P_DONE, 0);
            check("hold y", sr, 32'd3);
            step();
            chk_cycle("hold idle", P_IDLE, 0);
        end
        inicio = 1'b0;
        step();
        chk_cycle("final idle", P_IDLE, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
